// File: rtl/gauss_feed_pkg.sv
// Shared types and constants for the 3x3 window feeder in front of GaussFilter.
package gauss_feed_pkg;

   localparam int unsigned PIX_W    = 24;
   localparam int unsigned WIN_TAPS = 9;
   localparam int unsigned K_W      = 4;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      S_SCAN,
      S_EMIT
   } state_t;

   localparam rgb_t ZERO_PIX = '0;

endpackage

// File: rtl/rgb_line_buffer.sv
// One image line of RGB pixels: combinational read and synchronous write at the same column.
module rgb_line_buffer
   import gauss_feed_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] addr,
   input  rgb_t          wr_data,
   output rgb_t          rd_data_c
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rgb_t mem [DEPTH];
   logic in_range_c;

   // Column IMG_W is a padding column that has no storage behind it.
   assign in_range_c = (addr < AW'(DEPTH));
   assign rd_data_c  = in_range_c ? mem[addr[IW-1:0]] : ZERO_PIX;

   always_ff @(posedge clk) begin
      if (wr_en && in_range_c) begin
         mem[addr[IW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/gauss_window_feeder.sv
// Turns a raster RGB stream into zero-padded 3x3 neighbourhoods, nine taps per pixel,
// row-major, over a vld/busy handshake.
module gauss_window_feeder
   import gauss_feed_pkg::*;
#(
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pix_vld,
   input  logic [PIX_W-1:0] i_pix_data,
   output logic             o_pix_busy,
   output logic             o_rgb_vld,
   output logic [PIX_W-1:0] o_rgb_data,
   input  logic             i_rgb_busy,
   output logic             o_frame_done
);

   localparam int unsigned    XW     = $clog2(IMG_W + 1);
   localparam int unsigned    YW     = $clog2(IMG_H + 1);
   localparam logic [XW-1:0]  X_END  = XW'(IMG_W);
   localparam logic [YW-1:0]  Y_END  = YW'(IMG_H);
   localparam logic [K_W-1:0] K_LAST = K_W'(WIN_TAPS - 1);

   state_t         state_q, state_n;
   logic [XW-1:0]  x_q, x_n;
   logic [YW-1:0]  y_q, y_n;
   logic [K_W-1:0] k_q, k_n;
   logic           last_q, last_n;
   rgb_t           win_q [WIN_TAPS];
   rgb_t           win_n [WIN_TAPS];

   logic real_c, in_xfer_c, out_xfer_c, lb_we_c;
   rgb_t top_c, mid_c, bot_c, lb0_rd_c, lb1_rd_c;
   logic pix_busy_n, rgb_vld_n, frame_done_n;
   rgb_t rgb_data_n;

   // lb0 holds the previous line, lb1 the line before that.
   rgb_line_buffer #(.DEPTH(IMG_W), .AW(XW)) lb0 (
      .clk       (i_clk),
      .wr_en     (lb_we_c),
      .addr      (x_q),
      .wr_data   (bot_c),
      .rd_data_c (lb0_rd_c)
   );

   rgb_line_buffer #(.DEPTH(IMG_W), .AW(XW)) lb1 (
      .clk       (i_clk),
      .wr_en     (lb_we_c),
      .addr      (x_q),
      .wr_data   (lb0_rd_c),
      .rd_data_c (lb1_rd_c)
   );

   always_comb begin
      state_n      = state_q;
      x_n          = x_q;
      y_n          = y_q;
      k_n          = k_q;
      last_n       = last_q;
      win_n        = win_q;
      frame_done_n = 1'b0;
      lb_we_c      = 1'b0;

      real_c     = (x_q < X_END) && (y_q < Y_END);
      in_xfer_c  = i_pix_vld && !o_pix_busy;
      out_xfer_c = o_rgb_vld && !i_rgb_busy;
      top_c      = ((y_q >= YW'(2)) && (x_q < X_END)) ? lb1_rd_c : ZERO_PIX;
      mid_c      = ((y_q != '0) && (x_q < X_END)) ? lb0_rd_c : ZERO_PIX;
      bot_c      = real_c ? rgb_t'(i_pix_data) : ZERO_PIX;

      unique case (state_q)
         S_SCAN: begin
            // Padding positions advance without waiting for an input pixel.
            if (!real_c || in_xfer_c) begin
               lb_we_c = (x_q < X_END);
               if (x_q == '0) begin
                  win_n[0] = ZERO_PIX;
                  win_n[1] = ZERO_PIX;
                  win_n[3] = ZERO_PIX;
                  win_n[4] = ZERO_PIX;
                  win_n[6] = ZERO_PIX;
                  win_n[7] = ZERO_PIX;
               end else begin
                  win_n[0] = win_q[1];
                  win_n[1] = win_q[2];
                  win_n[3] = win_q[4];
                  win_n[4] = win_q[5];
                  win_n[6] = win_q[7];
                  win_n[7] = win_q[8];
               end
               win_n[2] = top_c;
               win_n[5] = mid_c;
               win_n[8] = bot_c;

               if ((x_q == X_END) && (y_q == Y_END)) begin
                  last_n = 1'b1;
               end else if (x_q == X_END) begin
                  x_n = '0;
                  y_n = y_q + YW'(1);
               end else begin
                  x_n = x_q + XW'(1);
               end

               if ((x_q != '0) && (y_q != '0)) begin
                  state_n = S_EMIT;
                  k_n     = '0;
               end
            end
         end
         S_EMIT: begin
            if (out_xfer_c) begin
               if (k_q == K_LAST) begin
                  k_n     = '0;
                  state_n = S_SCAN;
                  if (last_q) begin
                     last_n       = 1'b0;
                     x_n          = '0;
                     y_n          = '0;
                     frame_done_n = 1'b1;
                  end
               end else begin
                  k_n = k_q + K_W'(1);
               end
            end
         end
         default: state_n = S_SCAN;
      endcase

      // Outputs are registered from the next-state view so they line up with state.
      rgb_vld_n  = (state_n == S_EMIT);
      rgb_data_n = rgb_vld_n ? win_n[k_n] : ZERO_PIX;
      pix_busy_n = !((state_n == S_SCAN) && (x_n < X_END) && (y_n < Y_END));
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= S_SCAN;
         x_q          <= '0;
         y_q          <= '0;
         k_q          <= '0;
         last_q       <= 1'b0;
         win_q        <= '{default: ZERO_PIX};
         o_pix_busy   <= 1'b1;
         o_rgb_vld    <= 1'b0;
         o_rgb_data   <= '0;
         o_frame_done <= 1'b0;
      end else begin
         state_q      <= state_n;
         x_q          <= x_n;
         y_q          <= y_n;
         k_q          <= k_n;
         last_q       <= last_n;
         win_q        <= win_n;
         o_pix_busy   <= pix_busy_n;
         o_rgb_vld    <= rgb_vld_n;
         o_rgb_data   <= PIX_W'(rgb_data_n);
         o_frame_done <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Directed and randomized checks of gauss_window_feeder on a 4x4 image against a
// neighbourhood-enumeration reference model.
module tb_gauss_window_feeder;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;
   localparam int NTAP = 9 * NPIX;

   logic        i_clk      = 1'b0;
   logic        i_rst      = 1'b0;
   logic        i_pix_vld  = 1'b0;
   logic [23:0] i_pix_data = '0;
   logic        i_rgb_busy = 1'b0;
   logic        o_pix_busy;
   logic        o_rgb_vld;
   logic [23:0] o_rgb_data;
   logic        o_frame_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [23:0] pix [NPIX];
   logic [23:0] exp_tap [NTAP];
   logic [23:0] got [NTAP];
   logic [23:0] first_ref [9] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h1, 24'h0, 24'h4, 24'h5};
   logic [23:0] last_ref  [9] = '{24'hA, 24'hB, 24'h0, 24'hE, 24'hF, 24'h0, 24'h0, 24'h0, 24'h0};

   gauss_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pix_vld    (i_pix_vld),
      .i_pix_data   (i_pix_data),
      .o_pix_busy   (o_pix_busy),
      .o_rgb_vld    (o_rgb_vld),
      .o_rgb_data   (o_rgb_data),
      .i_rgb_busy   (i_rgb_busy),
      .o_frame_done (o_frame_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: every pixel's 3x3 neighbourhood in raster order, zero outside the image.
   task automatic build_golden();
      int n = 0;
      for (int cy = 0; cy < H; cy++)
         for (int cx = 0; cx < W; cx++)
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++) begin
                  int xx = cx + dx;
                  int yy = cy + dy;
                  exp_tap[n] = (xx >= 0 && xx < W && yy >= 0 && yy < H) ? pix[yy*W + xx] : 24'h0;
                  n++;
               end
   endtask

   // Runs one frame from a negedge; abort_at >= 0 stops mid-emit after that many taps.
   task automatic run_frame(input int vld_pct, input int busy_pct, input int hold_tap,
                            input int abort_at);
      int          n_in = 0, n_tap = 0, cyc = 0, hold_cnt = 0;
      bit          prev_last = 0, prev_stall = 0, prev_in_xfer = 0, seen_vld = 0;
      bit          in_xfer, out_xfer;
      logic [23:0] prev_data = '0;
      build_golden();
      forever begin
         chk("frame_done", 24'(o_frame_done), 24'(prev_last));
         if (prev_last) begin
            i_pix_vld  = 1'b0;
            i_rgb_busy = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            break;
         end
         if (o_rgb_vld) chk("busy_in_emit", 24'(o_pix_busy), 24'h1);
         if (prev_stall) begin
            chk("stall_vld", 24'(o_rgb_vld), 24'h1);
            chk("stall_data", o_rgb_data, prev_data);
         end
         if (o_rgb_vld && !seen_vld) begin
            seen_vld = 1;
            chk("latency_inputs", 24'(n_in), 24'd6);
            chk("latency_prev_xfer", 24'(prev_in_xfer), 24'h1);
         end
         if (abort_at >= 0 && n_tap >= abort_at && o_rgb_vld) begin
            i_pix_vld  = 1'b0;
            i_rgb_busy = 1'b0;
            return;
         end

         i_pix_vld  = (n_in < NPIX) && (($urandom % 100) < vld_pct);
         i_pix_data = (n_in < NPIX) ? pix[n_in] : 24'($urandom);
         i_rgb_busy = ($urandom % 100) < busy_pct;
         if (o_rgb_vld && n_tap == hold_tap && hold_cnt < 5) begin
            i_rgb_busy = 1'b1;
            hold_cnt++;
            chk("hold_data", o_rgb_data, exp_tap[hold_tap]);
            chk("hold_pix_busy", 24'(o_pix_busy), 24'h1);
         end

         in_xfer  = i_pix_vld && !o_pix_busy;
         out_xfer = o_rgb_vld && !i_rgb_busy;
         if (out_xfer) begin
            if (n_tap < NTAP) begin
               chk($sformatf("tap%0d", n_tap), o_rgb_data, exp_tap[n_tap]);
               got[n_tap] = o_rgb_data;
            end else begin
               chk("extra_tap", 24'(n_tap), 24'(NTAP - 1));
            end
            n_tap++;
         end
         if (in_xfer) n_in++;
         prev_last    = out_xfer && (n_tap == NTAP);
         prev_stall   = o_rgb_vld && i_rgb_busy;
         prev_data    = o_rgb_data;
         prev_in_xfer = in_xfer;

         @(posedge i_clk);
         @(negedge i_clk);
         cyc++;
         if (cyc > 3000) begin
            vectors++;
            miscompares++;
            $error("FAIL timeout: %0d inputs %0d taps after %0d cycles", n_in, n_tap, cyc);
            i_pix_vld  = 1'b0;
            i_rgb_busy = 1'b0;
            return;
         end
      end
      chk("inputs_per_frame", 24'(n_in), 24'(NPIX));
      chk("taps_per_frame", 24'(n_tap), 24'(NTAP));
   endtask

   task automatic check_reset_state();
      chk("rst_rgb_vld", 24'(o_rgb_vld), 24'h0);
      chk("rst_rgb_data", o_rgb_data, 24'h0);
      chk("rst_pix_busy", 24'(o_pix_busy), 24'h1);
      chk("rst_frame_done", 24'(o_frame_done), 24'h0);
   endtask

   task automatic release_reset();
      i_rst = 1'b1;
      chk("busy_at_release", 24'(o_pix_busy), 24'h1);
      @(posedge i_clk);
      @(negedge i_clk);
      chk("busy_after_release", 24'(o_pix_busy), 24'h0);
   endtask

   initial begin
      // Reset hold and release.
      repeat (3) @(negedge i_clk);
      check_reset_state();
      release_reset();

      // Ramp frame at full rate; spot-check first and last windows.
      for (int i = 0; i < NPIX; i++) pix[i] = 24'(i);
      run_frame(100, 0, -1, -1);
      for (int i = 0; i < 9; i++) chk($sformatf("first_win%0d", i), got[i], first_ref[i]);
      for (int i = 0; i < 9; i++) chk($sformatf("last_win%0d", i), got[NTAP-9+i], last_ref[i]);

      // Back-to-back ramp frame with a 5-cycle stall on the centre tap of window (1,1).
      run_frame(100, 0, (1*W + 1)*9 + 4, -1);

      // Random pixels with random input gaps and output back-pressure.
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
         run_frame(60, 40, -1, -1);
      end

      // Partial frame, then asynchronous reset while taps are being emitted.
      for (int i = 0; i < NPIX; i++) pix[i] = 24'($urandom);
      run_frame(100, 30, -1, 20);
      i_rst = 1'b0;
      #1;
      check_reset_state();
      repeat (2) @(negedge i_clk);
      release_reset();

      // Fresh ramp frame must match the clean-reset result exactly.
      for (int i = 0; i < NPIX; i++) pix[i] = 24'(i);
      run_frame(100, 0, -1, -1);
      for (int i = 0; i < 9; i++) chk($sformatf("post_rst_first%0d", i), got[i], first_ref[i]);
      for (int i = 0; i < 9; i++) chk($sformatf("post_rst_last%0d", i), got[NTAP-9+i], last_ref[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
